nucleo_cisc_param: RTL and testbench

//  Parametrised multi-cycle CISC core: FSM control, NREG x ANCHO register bank, ALU,
//  Z/C/V/N status register with conditional branches, PC, IR. Replaces the fixed

---
 rtl/nucleo_cisc_param.sv | 206 ++++++++++++++++++++
 tb/tb_nucleo_cisc_param.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/nucleo_cisc_param.sv
// Parametrised multi-cycle CISC core with a req/ack memory port that tolerates wait states.
// Instruction word: op in the top nibble, then rd, ra, rb fields of clog2(NREG) bits each.
module nucleo_cisc_param #(
    parameter int ANCHO = 16,
    parameter int NREG = 8,
    parameter int ANCHO_DIR = 16,
    parameter logic [ANCHO_DIR-1:0] VECTOR_INICIO = '0
) (
    input  logic                 Reloj,
    input  logic                 Reiniciar,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ANCHO_DIR-1:0] mem_dir,
    output logic [ANCHO-1:0]     mem_dout,
    input  logic [ANCHO-1:0]     mem_din,
    input  logic                 mem_ack,
    output logic [3:0]           estado,
    output logic                 detenido
);

    localparam int RW = $clog2(NREG);
    localparam int IW = 4 + 3 * RW;
    localparam int MSB = ANCHO - 1;
    localparam logic [ANCHO_DIR-1:0] UNO = 1;

    typedef enum logic [2:0] {
        BUSCA,
        DECODIFICA,
        EJECUTA,
        OPERANDO,
        LEE,
        ESCRIBE,
        DETENIDO
    } fase_t;

    fase_t                 fase, fase_sig;
    logic [ANCHO_DIR-1:0]  pc;
    logic [IW-1:0]         ir;
    logic [ANCHO-1:0]      regs [NREG];
    logic [ANCHO-1:0]      opa, opb;
    logic [3:0]            banderas;
    logic                  hueco;

    logic [3:0]            op;
    logic [RW-1:0]         rd, ra, rb;
    logic [ANCHO-1:0]      res;
    logic [ANCHO:0]        suma, resta;
    logic                  alu_c, alu_v;
    logic [ANCHO_DIR-1:0]  dir_reg, dir_palabra;

    assign op = ir[IW-1 -: 4];
    assign rd = ir[IW-5 -: RW];
    assign ra = ir[IW-5-RW -: RW];
    assign rb = ir[RW-1:0];

    assign dir_reg = ANCHO_DIR'(opa);
    assign dir_palabra = ANCHO_DIR'(mem_din);

    always_comb begin
        suma  = {1'b0, opa} + {1'b0, opb};
        resta = {1'b0, opa} - {1'b0, opb};
        res   = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            4'h1: begin
                res   = suma[MSB:0];
                alu_c = suma[ANCHO];
                alu_v = (opa[MSB] == opb[MSB]) && (res[MSB] != opa[MSB]);
            end
            4'h2: begin
                res   = resta[MSB:0];
                alu_c = resta[ANCHO];
                alu_v = (opa[MSB] != opb[MSB]) && (res[MSB] != opa[MSB]);
            end
            4'h3: res = opa & opb;
            4'h4: res = opa | opb;
            4'h5: res = opa ^ opb;
            4'h6: begin
                res   = {opa[MSB-1:0], 1'b0};
                alu_c = opa[MSB];
            end
            4'h7: begin
                res   = {1'b0, opa[MSB:1]};
                alu_c = opa[0];
            end
            default: res = '0;
        endcase
    end

    // The idle cycle after each completed data transaction is the BUSCA cycle with hueco set
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_dir  = '0;
        mem_dout = '0;
        case (fase)
            BUSCA: begin
                mem_req = !hueco;
                mem_dir = hueco ? '0 : pc;
            end
            OPERANDO: begin
                mem_req = 1'b1;
                mem_dir = pc;
            end
            LEE: begin
                mem_req = 1'b1;
                mem_dir = dir_reg;
            end
            ESCRIBE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_dir  = dir_reg;
                mem_dout = opb;
            end
            default: mem_req = 1'b0;
        endcase
    end

    assign estado   = banderas;
    assign detenido = (fase == DETENIDO);

    always_comb begin
        fase_sig = fase;
        case (fase)
            BUSCA:      if (mem_req && mem_ack) fase_sig = DECODIFICA;
            DECODIFICA: begin
                case (op)
                    4'h0:                      fase_sig = BUSCA;
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7:          fase_sig = EJECUTA;
                    4'h9:                      fase_sig = LEE;
                    4'hA:                      fase_sig = ESCRIBE;
                    4'hF:                      fase_sig = DETENIDO;
                    default:                   fase_sig = OPERANDO;
                endcase
            end
            EJECUTA:    fase_sig = BUSCA;
            OPERANDO,
            LEE,
            ESCRIBE:    if (mem_ack) fase_sig = BUSCA;
            default:    fase_sig = DETENIDO;
        endcase
    end

    // hueco starts set so that no request is issued in the first cycle after reset
    always_ff @(posedge Reloj) begin
        if (Reiniciar) begin
            fase     <= BUSCA;
            pc       <= VECTOR_INICIO;
            ir       <= '0;
            opa      <= '0;
            opb      <= '0;
            banderas <= '0;
            hueco    <= 1'b1;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            fase <= fase_sig;
            case (fase)
                BUSCA: begin
                    if (hueco) begin
                        hueco <= 1'b0;
                    end else if (mem_ack) begin
                        ir <= mem_din[ANCHO-1 -: IW];
                        pc <= pc + UNO;
                    end
                end
                DECODIFICA: begin
                    opa <= regs[ra];
                    opb <= regs[rb];
                end
                EJECUTA: begin
                    regs[rd] <= res;
                    banderas <= {(res == '0), alu_c, alu_v, res[MSB]};
                end
                OPERANDO: begin
                    if (mem_ack) begin
                        hueco <= 1'b1;
                        case (op)
                            4'h8: begin
                                regs[rd] <= mem_din;
                                pc       <= pc + UNO;
                            end
                            4'hB:    pc <= dir_palabra;
                            4'hC:    pc <= banderas[3] ? dir_palabra : pc + UNO;
                            4'hD:    pc <= banderas[2] ? dir_palabra : pc + UNO;
                            4'hE:    pc <= banderas[0] ? dir_palabra : pc + UNO;
                            default: pc <= pc + UNO;
                        endcase
                    end
                end
                LEE: begin
                    if (mem_ack) begin
                        regs[rd] <= mem_din;
                        hueco    <= 1'b1;
                    end
                end
                ESCRIBE: begin
                    if (mem_ack) hueco <= 1'b1;
                end
                default: hueco <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_nucleo_cisc_param.sv
// Directed bench for nucleo_cisc_param: the bench plays the memory, answering each request
// with hand-picked data and checking address, direction and write data of every transaction.
module tb_nucleo_cisc_param;

    logic        Reloj = 1'b0;
    logic        Reiniciar;
    logic        sel;
    logic        ackDrv;
    logic [31:0] dinDrv;

    logic        req16, we16, det16;
    logic [15:0] dir16, dout16;
    logic [3:0]  est16;
    logic        req32, we32, det32;
    logic [15:0] dir32;
    logic [31:0] dout32;
    logic [3:0]  est32;

    logic        reqM, weM;
    logic [15:0] dirM;
    logic [31:0] doutM;
    logic [3:0]  estM;

    int checks = 0;
    int failures = 0;

    always #5 Reloj = ~Reloj;

    nucleo_cisc_param u16 (
        .Reloj(Reloj), .Reiniciar(Reiniciar),
        .mem_req(req16), .mem_we(we16), .mem_dir(dir16), .mem_dout(dout16),
        .mem_din(dinDrv[15:0]), .mem_ack(ackDrv & ~sel),
        .estado(est16), .detenido(det16)
    );

    nucleo_cisc_param #(.ANCHO(32), .NREG(16)) u32 (
        .Reloj(Reloj), .Reiniciar(Reiniciar),
        .mem_req(req32), .mem_we(we32), .mem_dir(dir32), .mem_dout(dout32),
        .mem_din(dinDrv), .mem_ack(ackDrv & sel),
        .estado(est32), .detenido(det32)
    );

    assign reqM  = sel ? req32 : req16;
    assign weM   = sel ? we32 : we16;
    assign dirM  = sel ? dir32 : dir16;
    assign doutM = sel ? dout32 : {16'h0, dout16};
    assign estM  = sel ? est32 : est16;

    function automatic logic [15:0] i16(input int op, input int rd, input int ra, input int rb);
        return 16'((op << 12) | (rd << 9) | (ra << 6) | (rb << 3));
    endfunction

    function automatic logic [31:0] i32(input int op, input int rd, input int ra, input int rb);
        return 32'((op << 28) | (rd << 24) | (ra << 20) | (rb << 16));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at a negedge: waits for a request, checks it, holds ack low for 'waits' cycles
    // while checking the request stays put, then completes it and checks the idle gap.
    task automatic applyStimulus(input string tag, input int waits, input logic [31:0] rdata,
                                 input logic expWe, input logic [15:0] expDir,
                                 input logic [31:0] expDout);
        int n = 0;
        while (reqM !== 1'b1 && n < 200) begin
            @(negedge Reloj);
            n++;
        end
        checkOutput({tag, ".req"}, {31'h0, reqM}, 32'h1);
        checkOutput({tag, ".we"}, {31'h0, weM}, {31'h0, expWe});
        checkOutput({tag, ".dir"}, {16'h0, dirM}, {16'h0, expDir});
        checkOutput({tag, ".dout"}, doutM, expDout);
        for (int w = 0; w < waits; w++) begin
            @(negedge Reloj);
            checkOutput({tag, ".wreq"}, {31'h0, reqM}, 32'h1);
            checkOutput({tag, ".wwe"}, {31'h0, weM}, {31'h0, expWe});
            checkOutput({tag, ".wdir"}, {16'h0, dirM}, {16'h0, expDir});
            checkOutput({tag, ".wdout"}, doutM, expDout);
        end
        ackDrv = 1'b1;
        dinDrv = rdata;
        @(posedge Reloj);
        #1;
        ackDrv = 1'b0;
        dinDrv = '0;
        @(negedge Reloj);
        checkOutput({tag, ".gap"}, {31'h0, reqM}, 32'h0);
    endtask

    initial begin
        Reiniciar = 1'b1;
        sel = 1'b0;
        ackDrv = 1'b0;
        dinDrv = '0;
        repeat (2) @(negedge Reloj);
        Reiniciar = 1'b0;

        // Reset in the middle of a fetch that never gets acknowledged
        @(negedge Reloj);
        @(negedge Reloj);
        checkOutput("fetch0.req", {31'h0, req16}, 32'h1);
        checkOutput("fetch0.dir", {16'h0, dir16}, 32'h0);
        repeat (3) @(negedge Reloj);
        Reiniciar = 1'b1;
        @(negedge Reloj);
        Reiniciar = 1'b0;
        checkOutput("rst.req", {31'h0, req16}, 32'h0);
        checkOutput("rst.dir", {16'h0, dir16}, 32'h0);
        checkOutput("rst.estado", {28'h0, est16}, 32'h0);
        checkOutput("rst.detenido", {31'h0, det16}, 32'h0);

        applyStimulus("f00", 0, 32'(i16(10, 0, 0, 7)), 1'b0, 16'h0000, 32'h0);
        applyStimulus("st_r7", 0, 32'h0, 1'b1, 16'h0000, 32'h0);
        applyStimulus("f01", 0, 32'(i16(8, 1, 0, 0)), 1'b0, 16'h0001, 32'h0);
        applyStimulus("ldi_r1", 0, 32'h7FFF, 1'b0, 16'h0002, 32'h0);
        applyStimulus("f03", 0, 32'(i16(8, 2, 0, 0)), 1'b0, 16'h0003, 32'h0);
        applyStimulus("ldi_r2", 0, 32'h0001, 1'b0, 16'h0004, 32'h0);
        applyStimulus("f05", 0, 32'(i16(1, 3, 1, 2)), 1'b0, 16'h0005, 32'h0);
        applyStimulus("f06", 0, 32'(i16(10, 0, 0, 3)), 1'b0, 16'h0006, 32'h0);
        checkOutput("add.estado", {28'h0, est16}, 32'h3);
        applyStimulus("st_r3", 0, 32'h0, 1'b1, 16'h0000, 32'h8000);
        applyStimulus("f07", 0, 32'(i16(2, 4, 2, 2)), 1'b0, 16'h0007, 32'h0);
        applyStimulus("f08", 0, 32'(i16(12, 0, 0, 0)), 1'b0, 16'h0008, 32'h0);
        checkOutput("sub.estado", {28'h0, est16}, 32'h8);
        applyStimulus("brz", 0, 32'h0040, 1'b0, 16'h0009, 32'h0);
        applyStimulus("f40", 0, 32'(i16(13, 0, 0, 0)), 1'b0, 16'h0040, 32'h0);
        applyStimulus("brc_nt", 0, 32'h1234, 1'b0, 16'h0041, 32'h0);
        applyStimulus("f42", 0, 32'(i16(8, 5, 0, 0)), 1'b0, 16'h0042, 32'h0);
        applyStimulus("ldi_r5", 0, 32'h0010, 1'b0, 16'h0043, 32'h0);
        applyStimulus("f44", 0, 32'(i16(8, 7, 0, 0)), 1'b0, 16'h0044, 32'h0);
        applyStimulus("ldi_r7", 0, 32'hBEEF, 1'b0, 16'h0045, 32'h0);
        applyStimulus("f46", 0, 32'(i16(10, 0, 5, 7)), 1'b0, 16'h0046, 32'h0);
        applyStimulus("st_wait", 3, 32'h0, 1'b1, 16'h0010, 32'hBEEF);
        applyStimulus("f47", 1, 32'(i16(9, 6, 5, 0)), 1'b0, 16'h0047, 32'h0);
        applyStimulus("ld_r6", 2, 32'hBEEF, 1'b0, 16'h0010, 32'h0);
        applyStimulus("f48", 0, 32'(i16(10, 0, 0, 6)), 1'b0, 16'h0048, 32'h0);
        applyStimulus("st_r6", 0, 32'h0, 1'b1, 16'h0000, 32'hBEEF);
        applyStimulus("f49", 0, 32'(i16(6, 1, 3, 0)), 1'b0, 16'h0049, 32'h0);
        applyStimulus("f4a", 0, 32'(i16(13, 0, 0, 0)), 1'b0, 16'h004A, 32'h0);
        checkOutput("shl.estado", {28'h0, est16}, 32'hC);
        applyStimulus("brc_t", 0, 32'h0050, 1'b0, 16'h004B, 32'h0);
        applyStimulus("f50", 0, 32'(i16(5, 1, 7, 5)), 1'b0, 16'h0050, 32'h0);
        applyStimulus("f51", 0, 32'(i16(10, 0, 0, 1)), 1'b0, 16'h0051, 32'h0);
        checkOutput("xor.estado", {28'h0, est16}, 32'h1);
        applyStimulus("st_xor", 0, 32'h0, 1'b1, 16'h0000, 32'hBEFF);
        applyStimulus("f52", 0, 32'(i16(7, 2, 7, 0)), 1'b0, 16'h0052, 32'h0);
        applyStimulus("f53", 0, 32'(i16(10, 0, 0, 2)), 1'b0, 16'h0053, 32'h0);
        checkOutput("shr.estado", {28'h0, est16}, 32'h4);
        applyStimulus("st_shr", 0, 32'h0, 1'b1, 16'h0000, 32'h5F77);
        applyStimulus("f54", 0, 32'(i16(1, 3, 7, 7)), 1'b0, 16'h0054, 32'h0);
        applyStimulus("f55", 0, 32'(i16(14, 0, 0, 0)), 1'b0, 16'h0055, 32'h0);
        checkOutput("add2.estado", {28'h0, est16}, 32'h6);
        applyStimulus("brn_nt", 0, 32'h1111, 1'b0, 16'h0056, 32'h0);
        applyStimulus("f57", 0, 32'(i16(10, 0, 0, 3)), 1'b0, 16'h0057, 32'h0);
        applyStimulus("st_add2", 0, 32'h0, 1'b1, 16'h0000, 32'h7DDE);
        applyStimulus("f58", 0, 32'(i16(11, 0, 0, 0)), 1'b0, 16'h0058, 32'h0);
        applyStimulus("jmp", 0, 32'hFFFF, 1'b0, 16'h0059, 32'h0);
        applyStimulus("fFFFF", 0, 32'(i16(0, 0, 0, 0)), 1'b0, 16'hFFFF, 32'h0);
        applyStimulus("fwrap", 0, 32'(i16(15, 0, 0, 0)), 1'b0, 16'h0000, 32'h0);

        // HALT: no requests for 20 cycles even with ack driven high
        @(negedge Reloj);
        checkOutput("halt.detenido", {31'h0, det16}, 32'h1);
        ackDrv = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge Reloj);
            checkOutput("halt.req", {31'h0, req16}, 32'h0);
        end
        ackDrv = 1'b0;
        checkOutput("halt.detenido2", {31'h0, det16}, 32'h1);

        // 32-bit, 16-register core running the overflow program
        sel = 1'b1;
        @(negedge Reloj);
        applyStimulus("w00", 0, i32(8, 1, 0, 0), 1'b0, 16'h0000, 32'h0);
        applyStimulus("w_ldi1", 0, 32'h7FFFFFFF, 1'b0, 16'h0001, 32'h0);
        applyStimulus("w02", 0, i32(8, 2, 0, 0), 1'b0, 16'h0002, 32'h0);
        applyStimulus("w_ldi2", 0, 32'h00000001, 1'b0, 16'h0003, 32'h0);
        applyStimulus("w04", 0, i32(1, 3, 1, 2), 1'b0, 16'h0004, 32'h0);
        applyStimulus("w05", 0, i32(10, 0, 0, 3), 1'b0, 16'h0005, 32'h0);
        checkOutput("w_add.estado", {28'h0, estM}, 32'h3);
        applyStimulus("w_st", 0, 32'h0, 1'b1, 16'h0000, 32'h80000000);
        applyStimulus("w06", 0, i32(15, 0, 0, 0), 1'b0, 16'h0006, 32'h0);
        @(negedge Reloj);
        checkOutput("w_halt.detenido", {31'h0, det32}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
